// File: rtl/pixclk_pkg.sv
// Shared types and sizing helpers for the pixel clock controller.
package pixclk_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        SETTLE  = 2'd1,
        LOCKED  = 2'd2,
        DRAIN   = 2'd3
    } pix_state_t;

    localparam int DIV_WIDTH_DFLT = 8;

    // Width of a counter that must hold values 0..settle_ticks.
    function automatic int settle_cnt_width(input int settle_ticks);
        return $clog2(settle_ticks + 1);
    endfunction

endpackage

// File: rtl/period_counter.sv
// Loadable period counter: counts 0..load_val-1 and flags the terminal count.
module period_counter
    import pixclk_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DFLT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] load_val,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt;
    logic                 at_term;

    // Terminal count sits at load_val-1, so cnt can never exceed 2^DIV_WIDTH-2.
    assign at_term = (cnt == load_val - 1'b1);
    assign tick    = en && at_term;

    // Count while enabled, wrapping at terminal; clear has priority.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_term ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pixel_clock_controller.sv
// Pixel-rate divider sequencer: settles after start/reconfig, then strobes
// pix_ce once every cur_div cycles and reports lock to downstream timing.
module pixel_clock_controller
    import pixclk_pkg::*;
#(
    parameter int DIV_WIDTH    = DIV_WIDTH_DFLT,
    parameter int DEFAULT_DIV  = 4,
    parameter int SETTLE_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 cfg_valid,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    output logic                 cfg_ready,
    output logic                 cfg_err,
    output logic                 pix_ce,
    output logic                 locked,
    output logic [DIV_WIDTH-1:0] cur_div
);

    localparam int                   SW          = settle_cnt_width(SETTLE_TICKS);
    localparam logic [SW-1:0]        SETTLE_LAST = SW'(SETTLE_TICKS - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_RST     = DIV_WIDTH'(DEFAULT_DIV);

    pix_state_t           state;
    pix_state_t           state_nxt;
    logic [DIV_WIDTH-1:0] div_reg;
    logic [DIV_WIDTH-1:0] div_nxt;
    logic [DIV_WIDTH-1:0] pend_reg;
    logic [DIV_WIDTH-1:0] pend_nxt;
    logic [SW-1:0]        settle_cnt;
    logic [SW-1:0]        settle_nxt;
    logic                 accept;
    logic                 cfg_zero;
    logic                 tick;
    logic                 cnt_clr;
    logic                 cnt_en;
    logic                 ce_nxt;
    logic                 lock_nxt;
    logic                 err_nxt;

    // Config is only taken when the divider is idle or stably locked.
    assign cfg_ready = (state == STOPPED) || (state == LOCKED);
    assign accept    = cfg_valid && cfg_ready;
    assign cfg_zero  = (cfg_div == '0);
    assign cur_div   = div_reg;

    // Counter runs in every active state and is held at zero while stopped
    // or when run drops, so a restart always begins a fresh period.
    assign cnt_clr = (state == STOPPED) || !run;
    assign cnt_en  = (state != STOPPED);

    period_counter #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_period (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .load_val (div_reg),
        .tick     (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STOPPED;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dropping run overrides every state.
    always_comb begin
        state_nxt = state;
        if (!run) begin
            state_nxt = STOPPED;
        end else begin
            case (state)
                STOPPED: state_nxt = SETTLE;
                SETTLE:  if (tick && settle_cnt == SETTLE_LAST) state_nxt = LOCKED;
                LOCKED:  if (accept && !cfg_zero && cfg_div != div_reg) state_nxt = DRAIN;
                DRAIN:   if (tick) state_nxt = SETTLE;
                default: state_nxt = STOPPED;
            endcase
        end
    end

    // Ratio, pending ratio and settle-count updates.
    always_comb begin
        div_nxt    = div_reg;
        pend_nxt   = pend_reg;
        settle_nxt = '0;
        if (accept && !cfg_zero) begin
            // Stopped, or stopping this cycle: no period to finish, apply now.
            if (state == STOPPED || !run) begin
                div_nxt = cfg_div;
            end else begin
                pend_nxt = cfg_div;
            end
        end
        // Pending ratio takes effect at the end of the old period or on stop.
        if (state == DRAIN && (tick || !run)) begin
            div_nxt = pend_reg;
        end
        if (state == SETTLE && run) begin
            settle_nxt = tick ? settle_cnt + 1'b1 : settle_cnt;
        end
    end

    // Output logic: values the output registers take on the next edge.
    always_comb begin
        ce_nxt   = run && tick && (state == LOCKED || state == DRAIN);
        lock_nxt = (state_nxt == LOCKED) || (state_nxt == DRAIN);
        err_nxt  = accept && cfg_zero;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg    <= DIV_RST;
            pend_reg   <= DIV_RST;
            settle_cnt <= '0;
            pix_ce     <= 1'b0;
            locked     <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            div_reg    <= div_nxt;
            pend_reg   <= pend_nxt;
            settle_cnt <= settle_nxt;
            pix_ce     <= ce_nxt;
            locked     <= lock_nxt;
            cfg_err    <= err_nxt;
        end
    end

endmodule

// File: tb/tb_pixel_clock_controller.sv
// Directed bench for pixel_clock_controller (DIV_WIDTH=8, DEFAULT_DIV=4, SETTLE_TICKS=4).
// Cycle n is the interval after clock edge n-1; inputs set during cycle n
// are sampled by edge n.
module tb_pixel_clock_controller;

    logic       clk;
    logic       reset;
    logic       run;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       pix_ce;
    logic       locked;
    logic [7:0] cur_div;

    int         n_chk;
    int         n_pass;
    int         cyc;
    logic [7:0] cmax;

    pixel_clock_controller #(
        .DIV_WIDTH    (8),
        .DEFAULT_DIV  (4),
        .SETTLE_TICKS (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .pix_ce    (pix_ce),
        .locked    (locked),
        .cur_div   (cur_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        cyc       = 0;
        cmax      = '0;
        reset     = 1'b1;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_err",   32'(cfg_err),   32'd0);
        chk("rst_pix",   32'(pix_ce),    32'd0);
        chk("rst_lock",  32'(locked),    32'd0);
        chk("rst_div",   32'(cur_div),   32'd4);
        reset = 1'b0;
        step();
        chk("idle_pix",  32'(pix_ce),    32'd0);
        chk("idle_lock", 32'(locked),    32'd0);

        // Start-up at D=4, reconfig to 2, error cfg, no-op cfg
        cyc = 0;
        run = 1'b1;
        repeat (62) begin
            step();
            chk("su_pix", 32'(pix_ce),
                32'((cyc >= 21 && cyc <= 29 && (cyc - 21) % 4 == 0) || cyc == 33 ||
                    (cyc >= 43 && (cyc - 43) % 2 == 0)));
            chk("su_lock", 32'(locked), 32'((cyc >= 17 && cyc <= 32) || cyc >= 41));
            chk("su_ready", 32'(cfg_ready), 32'((cyc >= 17 && cyc <= 29) || cyc >= 41));
            chk("su_div", 32'(cur_div), (cyc >= 33) ? 32'd2 : 32'd4);
            chk("su_err", 32'(cfg_err), 32'(cyc == 51));
            cfg_valid = (cyc == 29) || (cyc == 50) || (cyc == 56);
            cfg_div   = (cyc == 50) ? 8'd0 : 8'd2;
            if (cyc == 62) run = 1'b0;
        end

        // Stopped
        step();
        chk("stop_pix",   32'(pix_ce),    32'd0);
        chk("stop_lock",  32'(locked),    32'd0);
        chk("stop_ready", 32'(cfg_ready), 32'd1);
        chk("stop_div",   32'(cur_div),   32'd2);

        // D=1 configured in the same cycle as start, then stop while strobing
        cyc       = 0;
        run       = 1'b1;
        cfg_valid = 1'b1;
        cfg_div   = 8'd1;
        repeat (13) begin
            step();
            chk("d1_pix",   32'(pix_ce),    32'(cyc >= 6 && cyc <= 12));
            chk("d1_lock",  32'(locked),    32'(cyc >= 5 && cyc <= 12));
            chk("d1_ready", 32'(cfg_ready), 32'(cyc >= 5));
            chk("d1_div",   32'(cur_div),   32'd1);
            cfg_valid = 1'b0;
            if (cyc == 12) run = 1'b0;
        end

        // D=255, then reconfig to 6 and stop mid-DRAIN
        cyc       = 0;
        run       = 1'b1;
        cfg_valid = 1'b1;
        cfg_div   = 8'd255;
        repeat (1800) begin
            step();
            chk("d255_pix", 32'(pix_ce),
                32'(cyc >= 1276 && cyc <= 1795 && (cyc - 1276) % 255 == 0));
            chk("d255_lock",  32'(locked),    32'(cyc >= 1021 && cyc <= 1795));
            chk("d255_ready", 32'(cfg_ready), 32'((cyc >= 1021 && cyc <= 1790) || cyc >= 1796));
            chk("d255_div",   32'(cur_div),   (cyc >= 1796) ? 32'd6 : 32'd255);
            if (cyc <= 1795 && dut.u_period.cnt > cmax) cmax = dut.u_period.cnt;
            cfg_valid = (cyc == 1790);
            cfg_div   = 8'd6;
            if (cyc == 1795) run = 1'b0;
        end
        chk("d255_cnt_max", 32'(cmax), 32'd254);

        // Restart at the ratio applied during the interrupted drain
        cyc       = 0;
        run       = 1'b1;
        cfg_valid = 1'b0;
        repeat (40) begin
            step();
            chk("d6_pix",   32'(pix_ce),    32'(cyc == 31 || cyc == 37));
            chk("d6_lock",  32'(locked),    32'(cyc >= 25));
            chk("d6_ready", 32'(cfg_ready), 32'(cyc >= 25));
            chk("d6_div",   32'(cur_div),   32'd6);
        end

        // Reset while locked, with a cfg offered during reset
        reset     = 1'b1;
        cfg_valid = 1'b1;
        cfg_div   = 8'd9;
        step();
        chk("mrst_pix",   32'(pix_ce),    32'd0);
        chk("mrst_lock",  32'(locked),    32'd0);
        chk("mrst_err",   32'(cfg_err),   32'd0);
        chk("mrst_ready", 32'(cfg_ready), 32'd1);
        chk("mrst_div",   32'(cur_div),   32'd4);
        step();
        chk("mrst_div2",  32'(cur_div),   32'd4);
        chk("mrst_lock2", 32'(locked),    32'd0);
        reset     = 1'b0;
        cfg_valid = 1'b0;
        run       = 1'b0;
        step();
        chk("post_div",  32'(cur_div), 32'd4);
        chk("post_lock", 32'(locked),  32'd0);
        chk("post_pix",  32'(pix_ce),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pixel_clock_controller.md
Name: pixel_clock_controller

Overview:
- Sequences and reconfigures the pixel-rate divider for the VGA pipeline.
- Produces a one-`clk` pixel clock-enable strobe `pix_ce` every D cycles.
- Accepts divide-ratio changes over a valid/ready handshake and switches only on a period boundary.
- Suppresses `pix_ce` for a settle window after start or reconfiguration; downstream timing logic waits for `locked` before counting pixels.

Parameters:
- DIV_WIDTH, 8, width of the divide ratio and period counter
- DEFAULT_DIV, 4, divide ratio loaded at reset (must be ≥1)
- SETTLE_TICKS, 4, internal ticks suppressed after start or reconfig before locking (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  level; 1 = generate, 0 = stop
- cfg_valid  in  1  new divide ratio offered
- cfg_div  in  DIV_WIDTH  requested ratio D
- cfg_ready  out  1  controller can accept cfg this cycle
- cfg_err  out  1  one-cycle pulse: accepted cfg had D=0 and was discarded
- pix_ce  out  1  registered pixel clock-enable strobe
- locked  out  1  `pix_ce` valid and periodic at `cur_div`
- cur_div  out  DIV_WIDTH  ratio currently in effect

Behaviour:
- **Reset values:** state=STOPPED, div_reg=DEFAULT_DIV, cnt=0, settle_cnt=0, pix_ce=0, locked=0, cfg_err=0, cfg_ready=1, cur_div=DEFAULT_DIV. Reset dominates all inputs, mid-operation included.
- **States:** STOPPED, SETTLE, LOCKED, DRAIN.
- **Counting:** in SETTLE, LOCKED and DRAIN, cnt increments every cycle. tick = (cnt == div_reg-1); on tick, cnt wraps to 0. In STOPPED, cnt is held at 0.
- **Strobe:** pix_ce register <= tick && state∈{LOCKED, DRAIN}. One-cycle latency from tick. D=1 gives pix_ce constantly high while locked.
- **Handshake:** accept = cfg_valid && cfg_ready. cfg_ready=1 in STOPPED and LOCKED, 0 in SETTLE and DRAIN. An accepted D=0 pulses cfg_err the next cycle; nothing else changes.
- **STOPPED:**
  - accepted D≠0 -> div_reg=D next cycle.
  - run=1 -> SETTLE next cycle with cnt=0, settle_cnt=0. If a cfg is accepted in the same cycle, the new D is used.
- **SETTLE:**
  - Each tick increments settle_cnt.
  - On the tick that makes settle_cnt==SETTLE_TICKS -> LOCKED next cycle.
  - locked = registered (state==LOCKED or DRAIN).
- **LOCKED:**
  - accepted D==div_reg -> no-op.
  - accepted D≠div_reg (and ≠0) -> latch pending=D, go to DRAIN.
- **DRAIN:**
  - Old period completes, and the final tick still emits pix_ce.
  - On that tick: div_reg<=pending, cnt<=0, settle_cnt<=0, state<=SETTLE. locked drops the following cycle.
- **run=0 in any state:** STOPPED next cycle; cnt=0, locked=0. pix_ce=0 from the next cycle; an in-flight strobe registered in the same edge is suppressed.
  - run=0 in DRAIN: pending is applied to div_reg immediately.
  - run=0 while a cfg is accepted in LOCKED: D is applied directly and the controller stops.
- **cur_div** = div_reg.
- **Widths:** ratio is unsigned. Maximum D = 2^DIV_WIDTH−1. cnt is DIV_WIDTH bits; no overflow is possible because the wrap happens at D−1.

Decomposition:
- Package `pixclk_pkg`:
  - state enum {STOPPED, SETTLE, LOCKED, DRAIN}
  - default DIV_WIDTH
  - SETTLE counter width: clog2(SETTLE_TICKS+1)
- One sub-module, `period_counter`: loadable DIV_WIDTH counter with synchronous clear, enable, and a tick output at terminal count (terminal = load value−1).
- FSM, handshake and output registers live in `pixel_clock_controller`.

Test Plan:
- **Start-up:** reset, then run=1 sampled at cycle 0, D=4, S=4 -> SETTLE from cycle 1; ticks at 4, 8, 12, 16; locked=1 at cycle 17; pix_ce high at cycles 21, 25, 29…; no pix_ce before 21.
- **Reconfig:** locked at D=4, accept cfg_div=2 one cycle after a tick -> cfg_ready=0; old-ratio pix_ce fires once more after the old tick; locked drops; 4 ticks at spacing 2 follow; locked=1; then pix_ce every 2 cycles; cur_div=2.
- **Error and no-op cfg:** cfg_div=0 while LOCKED -> cfg_err pulses 1 cycle, pix_ce cadence unchanged. cfg_div equal to current -> no DRAIN, locked stays 1.
- **D=1 and D=255:** D=1 -> pix_ce continuously high once locked. D=255 -> pix_ce spacing exactly 255 cycles; cnt never exceeds 254.
- **Stop mid-DRAIN:** run=0 during DRAIN with pending=6 -> STOPPED next cycle, pix_ce=0, locked=0, cur_div=6. Then run=1 -> settles at D=6.
- **Reset mid-operation:** assert reset during LOCKED -> all outputs at reset values next cycle, cur_div=DEFAULT_DIV; cfg_valid held high during reset is not accepted.
